// File: rtl/alu_flags.sv
// Flag-capture and branch-condition stage behind the 8-bit ALU. Tracks each ALU operation
// through start/done, latches {N,V,C,Z} on completion and resolves jump conditions.
module alu_flags #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       done,
    input  logic [7:0] result,
    input  logic       carry,
    input  logic       overflow,
    input  logic       cmpo,
    input  logic       clr,
    input  logic       jump_req,
    input  logic [2:0] cond,
    output logic [3:0] flags,
    output logic       captured,
    output logic       timeout_err,
    output logic       busy,
    output logic       take,
    output logic       take_valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    logic       expire;
    logic       eval;
    logic       cond_true;

    // The counter hits TIMEOUT on this edge; this beats a done seen in the same cycle.
    assign expire = (state != IDLE) && (cnt == 8'(TIMEOUT - 1));
    assign eval   = (state == IDLE) && jump_req && !start;
    assign busy   = (state != IDLE);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'd0:    cond_true = 1'b1;
            3'd1:    cond_true = flags[0];
            3'd2:    cond_true = !flags[0];
            3'd3:    cond_true = flags[1];
            3'd4:    cond_true = !flags[1];
            3'd5:    cond_true = flags[3];
            3'd6:    cond_true = flags[2];
            default: cond_true = flags[3] ^ flags[2];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            flags       <= 4'd0;
            captured    <= 1'b0;
            timeout_err <= 1'b0;
            take        <= 1'b0;
            take_valid  <= 1'b0;
        end else begin
            captured   <= 1'b0;
            take_valid <= eval;
            if (eval) begin
                take <= cond_true;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARMED;
                        cnt   <= 8'd0;
                    end
                end
                ARMED: begin
                    cnt <= cnt + 8'd1;
                    if (expire) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else if (!done) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (expire) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else if (done) begin
                        state <= IDLE;
                        if (cmpo) begin
                            captured <= 1'b1;
                            flags    <= {result[7], overflow, carry, (result == 8'd0)};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Clear overrides any capture or timeout in the same cycle.
            if (clr) begin
                flags       <= 4'd0;
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_flags.sv
// Directed bench for alu_flags: a behavioural model checked every cycle, plus literal
// expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_alu_flags;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       done = 1'b1;
    logic [7:0] result = 8'd0;
    logic       carry = 1'b0;
    logic       overflow = 1'b0;
    logic       cmpo = 1'b0;
    logic       clr = 1'b0;
    logic       jump_req = 1'b0;
    logic [2:0] cond = 3'd0;
    logic [3:0] flags;
    logic       captured;
    logic       timeout_err;
    logic       busy;
    logic       take;
    logic       take_valid;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    alu_flags #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done), .result(result),
        .carry(carry), .overflow(overflow), .cmpo(cmpo), .clr(clr),
        .jump_req(jump_req), .cond(cond), .flags(flags), .captured(captured),
        .timeout_err(timeout_err), .busy(busy), .take(take), .take_valid(take_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_holds(input logic [2:0] c, input logic [3:0] f);
        logic n, v, cy, z;
        n = f[3]; v = f[2]; cy = f[1]; z = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return n;
            3'd6: return v;
            default: return n ^ v;
        endcase
    endfunction

    // Model: phase 0 = no op, 1 = waiting for ALU to accept, 2 = ALU running.
    int         m_phase = 0;
    int         m_age = 0;
    logic [3:0] m_flags = 4'd0;
    logic       m_cap = 1'b0;
    logic       m_terr = 1'b0;
    logic       m_take = 1'b0;
    logic       m_tv = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit ev;
        if (!rst_n) begin
            m_phase = 0; m_age = 0; m_flags = 4'd0;
            m_cap = 1'b0; m_terr = 1'b0; m_take = 1'b0; m_tv = 1'b0;
        end else begin
            ev = (m_phase == 0) && jump_req && !start;
            m_tv  = ev;
            m_cap = 1'b0;
            if (ev) m_take = cond_holds(cond, m_flags);
            if (m_phase == 0) begin
                if (start) begin
                    m_phase = 1;
                    m_age   = 0;
                end
            end else begin
                m_age++;
                if (m_age >= TIMEOUT) begin
                    m_terr  = 1'b1;
                    m_phase = 0;
                end else if (m_phase == 1 && !done) begin
                    m_phase = 2;
                end else if (m_phase == 2 && done) begin
                    m_phase = 0;
                    if (cmpo) begin
                        m_cap   = 1'b1;
                        m_flags = {result[7], overflow, carry, result == 8'd0};
                    end
                end
            end
            if (clr) begin
                m_flags = 4'd0;
                m_terr  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("m_flags", 32'(flags), 32'(m_flags));
            check("m_captured", 32'(captured), 32'(m_cap));
            check("m_timeout_err", 32'(timeout_err), 32'(m_terr));
            check("m_busy", 32'(busy), 32'(m_phase != 0));
            check("m_take_valid", 32'(take_valid), 32'(m_tv));
            if (m_tv) check("m_take", 32'(take), 32'(m_take));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ALU operation: ALU accepts right after start, runs, then raises done with its outputs.
    task automatic alu_op(input logic [7:0] res, input logic c, input logic v, input logic cm,
                          input int run, input logic jmp, input logic [2:0] jc, input logic clr_done);
        start = 1'b1;
        tick();
        start = 1'b0;
        done  = 1'b0;
        if (jmp) begin
            jump_req = 1'b1;
            cond     = jc;
        end
        repeat (run) tick();
        result   = res;
        carry    = c;
        overflow = v;
        cmpo     = cm;
        done     = 1'b1;
        clr      = clr_done;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_outs", 32'({captured, timeout_err, take, take_valid}), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        check_en = 1'b1;
        tick();

        // 0xFF + 0x01: zero result with carry out
        alu_op(8'h00, 1'b1, 1'b0, 1'b1, 3, 1'b0, 3'd0, 1'b0);
        check("op1_flags", 32'(flags), 32'h3);
        check("op1_captured", 32'(captured), 32'h1);
        check("op1_busy", 32'(busy), 32'h0);
        tick();
        check("op1_cap_pulse", 32'(captured), 32'h0);

        // cmpo=0 leaves prior flags
        alu_op(8'h80, 1'b0, 1'b0, 1'b1, 2, 1'b0, 3'd0, 1'b0);
        check("op2_prior", 32'(flags), 32'h8);
        alu_op(8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b0, 3'd0, 1'b0);
        check("op2_flags", 32'(flags), 32'h8);
        check("op2_captured", 32'(captured), 32'h0);

        // Stalled NZ jump raised during the op
        alu_op(8'h05, 1'b0, 1'b0, 1'b1, 3, 1'b1, 3'd2, 1'b0);
        check("nz_no_tv_at_cap", 32'(take_valid), 32'h0);
        tick();
        check("nz_tv", 32'(take_valid), 32'h1);
        check("nz_take", 32'(take), 32'h1);
        jump_req = 1'b0;
        tick();
        check("nz_tv_drop", 32'(take_valid), 32'h0);

        // Signed less-than
        alu_op(8'h80, 1'b0, 1'b1, 1'b1, 2, 1'b1, 3'd7, 1'b0);
        check("lt1_flags", 32'(flags), 32'hC);
        tick();
        check("lt1_tv", 32'(take_valid), 32'h1);
        check("lt1_take", 32'(take), 32'h0);
        jump_req = 1'b0;
        tick();
        alu_op(8'h80, 1'b0, 1'b0, 1'b1, 2, 1'b1, 3'd7, 1'b0);
        tick();
        check("lt2_tv", 32'(take_valid), 32'h1);
        check("lt2_take", 32'(take), 32'h1);
        jump_req = 1'b0;
        tick();

        // Held jump in IDLE: one evaluation per cycle with flags 1000
        jump_req = 1'b1;
        cond = 3'd0; tick(); check("held_always", 32'({take_valid, take}), 32'h3);
        cond = 3'd3; tick(); check("held_c", 32'({take_valid, take}), 32'h2);
        cond = 3'd5; tick(); check("held_n", 32'({take_valid, take}), 32'h3);
        cond = 3'd4; tick(); check("held_nc", 32'({take_valid, take}), 32'h3);
        cond = 3'd1; tick(); check("held_z", 32'({take_valid, take}), 32'h2);

        // Jump coinciding with start stalls; evaluated on the new Z flag
        alu_op(8'h00, 1'b0, 1'b0, 1'b1, 2, 1'b0, 3'd0, 1'b0);
        check("co_no_tv", 32'(take_valid), 32'h0);
        tick();
        check("co_tv_take", 32'({take_valid, take}), 32'h3);
        jump_req = 1'b0;
        tick();

        // clr coinciding with capture
        alu_op(8'h80, 1'b1, 1'b1, 1'b1, 2, 1'b0, 3'd0, 1'b1);
        check("clrcap_captured", 32'(captured), 32'h1);
        check("clrcap_flags", 32'(flags), 32'h0);
        tick();

        // Asynchronous reset mid-BUSY
        alu_op(8'h80, 1'b0, 1'b0, 1'b1, 2, 1'b0, 3'd0, 1'b0);
        start = 1'b1; tick();
        start = 1'b0; done = 1'b0; tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_flags", 32'(flags), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_outs", 32'({captured, timeout_err, take, take_valid}), 32'h0);
        tick();
        rst_n  = 1'b1;
        result = 8'h00; cmpo = 1'b1; done = 1'b1;
        tick();
        check("late_done_cap", 32'(captured), 32'h0);
        check("late_done_flags", 32'(flags), 32'h0);
        tick();

        // Timeout with done stuck high
        alu_op(8'h80, 1'b0, 1'b0, 1'b1, 2, 1'b0, 3'd0, 1'b0);
        start = 1'b1; tick();
        start = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            check("to_wait", 32'({busy, timeout_err}), 32'h2);
        end
        tick();
        check("to_err", 32'(timeout_err), 32'h1);
        check("to_busy", 32'(busy), 32'h0);
        check("to_flags", 32'(flags), 32'h8);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_err", 32'(timeout_err), 32'h0);
        check("clr_flags", 32'(flags), 32'h0);
        tick();
        tick();

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
